// File: rtl/eprisc_iobus_master.sv
`default_nettype none
// ============================================================================
// Module   : eprisc_iobus_master
// Purpose  : Host-side master for the epRISC I/O controller byte-serial bus.
//            Runs one 32-bit register transaction per request and syncs the IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module eprisc_iobus_master #(
    parameter int unsigned DIV         = 2,
    parameter logic [1:0]  SELECT_CODE = 2'h1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oBusy,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt,
    output logic        oInterrupt
);

    localparam int unsigned         c_CNT_W    = $clog2(2 * DIV);
    localparam logic [c_CNT_W-1:0]  c_CNT_RISE = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(2 * DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state,       w_state;
    logic [c_CNT_W-1:0]  r_cnt,         w_cnt;
    logic [2:0]          r_edgeCnt,     w_edgeCnt;
    logic                r_secondFrame, w_secondFrame;
    logic [31:0]         r_word,        w_word;
    logic                r_busClock,    w_busClock;
    logic [1:0]          r_busSelect,   w_busSelect;
    logic [7:0]          r_busMOSI,     w_busMOSI;
    logic [31:0]         r_rspData,     w_rspData;
    logic                r_rspValid,    w_rspValid;
    logic [7:0]          w_txByte;
    logic                r_intMeta;
    logic                r_intSync;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_edgeCnt     <= 3'd1;
            r_secondFrame <= 1'b0;
            r_word        <= '0;
            r_busClock    <= 1'b0;
            r_busSelect   <= 2'b00;
            r_busMOSI     <= 8'h00;
            r_rspData     <= '0;
            r_rspValid    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_edgeCnt     <= w_edgeCnt;
            r_secondFrame <= w_secondFrame;
            r_word        <= w_word;
            r_busClock    <= w_busClock;
            r_busSelect   <= w_busSelect;
            r_busMOSI     <= w_busMOSI;
            r_rspData     <= w_rspData;
            r_rspValid    <= w_rspValid;
        end
    end

    // r_cnt walks one bus period (0..2D-1); r_edgeCnt numbers the period (7 = gap)
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_edgeCnt     = r_edgeCnt;
        w_secondFrame = r_secondFrame;
        w_word        = r_word;
        w_busClock    = r_busClock;
        w_busSelect   = r_busSelect;
        w_busMOSI     = r_busMOSI;
        w_rspData     = r_rspData;
        w_rspValid    = 1'b0;

        case (r_edgeCnt)
            3'd1:    w_txByte = r_word[7:0];
            3'd2:    w_txByte = r_word[15:8];
            3'd3:    w_txByte = r_word[23:16];
            3'd4:    w_txByte = r_word[31:24];
            default: w_txByte = 8'h00;
        endcase

        case (r_state)
            S_IDLE: begin
                if (iReqValid) begin
                    w_state       = S_FRAME;
                    w_word        = {iReqWrite, iReqAddr, iReqData};
                    w_cnt         = '0;
                    w_edgeCnt     = 3'd1;
                    w_secondFrame = 1'b0;
                    w_busSelect   = SELECT_CODE;
                    w_busClock    = 1'b0;
                end
            end
            S_FRAME, S_GAP: begin
                if (r_cnt == c_CNT_RISE) begin
                    w_cnt      = r_cnt + 1'b1;
                    w_busClock = 1'b1;
                    if (r_edgeCnt <= 3'd5) begin
                        w_busMOSI = w_txByte;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cnt      = '0;
                    w_busClock = 1'b0;
                    // MISO is taken before the slave sees this falling edge
                    case (r_edgeCnt)
                        3'd1:    w_rspData[7:0]   = iBusMISO;
                        3'd2:    w_rspData[15:8]  = iBusMISO;
                        3'd3:    w_rspData[23:16] = iBusMISO;
                        3'd4:    w_rspData[31:24] = iBusMISO;
                        default: ;
                    endcase
                    if (r_edgeCnt == 3'd6) begin
                        w_state     = S_GAP;
                        w_busSelect = 2'b00;
                        w_edgeCnt   = 3'd7;
                    end else if (r_edgeCnt == 3'd7) begin
                        // Read data arrives one frame late, so reads repeat the frame
                        if (!r_word[31] && !r_secondFrame) begin
                            w_state       = S_FRAME;
                            w_secondFrame = 1'b1;
                            w_edgeCnt     = 3'd1;
                            w_busSelect   = SELECT_CODE;
                        end else begin
                            w_state    = S_DONE;
                            w_rspValid = 1'b1;
                        end
                    end else begin
                        w_edgeCnt = r_edgeCnt + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_intMeta <= 1'b0;
            r_intSync <= 1'b0;
        end else begin
            r_intMeta <= iBusInterrupt;
            r_intSync <= r_intMeta;
        end
    end

    assign oReqReady  = (r_state == S_IDLE) && !iRst;
    assign oBusy      = (r_state != S_IDLE);
    assign oRspValid  = r_rspValid;
    assign oRspData   = r_rspData;
    assign oBusClock  = r_busClock;
    assign oBusSelect = r_busSelect;
    assign oBusMOSI   = r_busMOSI;
    assign oInterrupt = r_intSync;

endmodule
`default_nettype wire

// File: tb/tb_eprisc_iobus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_eprisc_iobus_master
// Purpose  : Self-checking bench for eprisc_iobus_master against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eprisc_iobus_master;

    localparam int         DIV       = 2;
    localparam logic [1:0] SEL       = 2'h1;
    localparam int         FRAME_LEN = 14 * DIV;

    logic        iClk          = 1'b0;
    logic        iRst          = 1'b1;
    logic        iReqValid     = 1'b0;
    logic        iReqWrite     = 1'b0;
    logic [14:0] iReqAddr      = '0;
    logic [15:0] iReqData      = '0;
    logic [7:0]  iBusMISO      = '0;
    logic        iBusInterrupt = 1'b0;
    logic        oReqReady;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oBusy;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic        oInterrupt;

    always #5 iClk = ~iClk;

    eprisc_iobus_master #(
        .DIV         (DIV),
        .SELECT_CODE (SEL)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iReqValid     (iReqValid),
        .oReqReady     (oReqReady),
        .iReqWrite     (iReqWrite),
        .iReqAddr      (iReqAddr),
        .iReqData      (iReqData),
        .oRspValid     (oRspValid),
        .oRspData      (oRspData),
        .oBusy         (oBusy),
        .oBusClock     (oBusClock),
        .oBusSelect    (oBusSelect),
        .oBusMOSI      (oBusMOSI),
        .iBusMISO      (iBusMISO),
        .iBusInterrupt (iBusInterrupt),
        .oInterrupt    (oInterrupt)
    );

    int          passCount = 0;
    int          failCount = 0;
    int          checkCount = 0;
    int          cyc = 0;
    bit          mActive = 1'b0;
    int          mStart = 0;
    int          mFrames = 0;
    logic [31:0] mWord = '0;
    logic [31:0] mMiso [2];
    logic [31:0] mLastRsp = '0;
    logic [1:0]  mIntHist = '0;
    int          accCount = 0;
    int          accCycle = 0;
    int          rspCount = 0;
    int          rspCycle = 0;
    int          selCount = 0;
    int          intHighCount = 0;
    int          firstIntHigh = -1;
    logic        prevBusClk = 1'b0;
    logic [7:0]  mosiLog [$];
    bit          randIrq = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Register contents the slave returns for a read of a given address
    function automatic logic [31:0] readValue(input logic [14:0] a);
        if (a == 15'h0100) return 32'h1234_5678;
        return {a, 2'b10, ~a};
    endfunction

    task automatic tick();
        logic        acc, rstAtEdge, irqAtEdge, wr;
        logic [14:0] a;
        logic [15:0] d;
        int          t, u, h, r;
        logic        expBusy, expClk, expValid;
        logic [1:0]  expSel;
        logic [7:0]  expMosi;
        #1;
        rstAtEdge = iRst;
        irqAtEdge = iBusInterrupt;
        acc       = iReqValid && !iRst && !mActive;
        wr        = iReqWrite;
        a         = iReqAddr;
        d         = iReqData;
        @(posedge iClk);
        cyc++;
        if (rstAtEdge) begin
            mActive  = 1'b0;
            mLastRsp = '0;
            mIntHist = '0;
        end else begin
            mIntHist = {mIntHist[0], irqAtEdge};
            if (mActive && (cyc - mStart) > mFrames * FRAME_LEN) mActive = 1'b0;
            if (acc) begin
                mActive  = 1'b1;
                mStart   = cyc;
                accCycle = cyc - 1;
                accCount++;
                mWord    = {wr, a, d};
                mFrames  = wr ? 1 : 2;
                mMiso[0] = $urandom;
                mMiso[1] = readValue(a);
            end
        end
        #1;
        expBusy = 1'b0; expClk = 1'b0; expValid = 1'b0; expSel = 2'b00; expMosi = 8'h00;
        t = cyc - mStart;
        if (mActive) begin
            expBusy = 1'b1;
            if (t == mFrames * FRAME_LEN) begin
                expValid = 1'b1;
                mLastRsp = mMiso[mFrames-1];
            end else begin
                u = t % FRAME_LEN;
                h = u / DIV;
                r = (h + 1) / 2;
                expClk = (h % 2 == 1);
                expSel = (h < 12) ? SEL : 2'b00;
                if (r >= 1 && r <= 4) expMosi = mWord[8*(r-1) +: 8];
            end
        end
        check("bus_outputs", 64'({oBusy, oBusClock, oBusSelect, oBusMOSI, oRspValid}),
              64'({expBusy, expClk, expSel, expMosi, expValid}));
        check("req_ready", 64'(oReqReady), 64'(!iRst && !mActive));
        check("interrupt", 64'(oInterrupt), 64'(mIntHist[1]));
        if (!mActive || expValid) check("rsp_data", 64'(oRspData), 64'(mLastRsp));

        if (oRspValid) begin rspCount++; rspCycle = cyc; end
        if (oBusClock && !prevBusClk) mosiLog.push_back(oBusMOSI);
        prevBusClk = oBusClock;
        if (oBusSelect == SEL) selCount++;
        if (oInterrupt) begin
            intHighCount++;
            if (firstIntHigh < 0) firstIntHigh = cyc;
        end

        // Slave drives byte k-1 while the bus clock is high after rising edge k
        iBusMISO = 8'($urandom);
        if (mActive && t < mFrames * FRAME_LEN) begin
            u = t % FRAME_LEN;
            h = u / DIV;
            if (h % 2 == 1 && h <= 7) iBusMISO = mMiso[t / FRAME_LEN][8*((h-1)/2) +: 8];
        end
        if (randIrq) iBusInterrupt = 1'($urandom_range(0, 1));
    endtask

    task automatic waitAccept(input int bound);
        int start, n;
        start = accCount;
        n = 0;
        while (accCount == start && n < bound) begin tick(); n++; end
        check("accept_timeout", 64'(accCount != start), 64'(1));
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (oBusy && n < bound) begin tick(); n++; end
        check("idle_timeout", 64'(oBusy), 64'(0));
    endtask

    task automatic issue(input logic wr, input logic [14:0] a, input logic [15:0] d);
        iReqValid = 1'b1;
        iReqWrite = wr;
        iReqAddr  = a;
        iReqData  = d;
        waitAccept(200);
        iReqValid = 1'b0;
    endtask

    initial begin
        int r0, raise;
        logic wr;
        logic [14:0] a;

        repeat (3) tick();
        check("reset_outputs", 64'({oReqReady, oRspValid, oBusy, oBusClock, oBusSelect,
              oBusMOSI, oInterrupt, oRspData}), 64'(0));
        iRst = 1'b0;
        #1;
        check("ready_after_release", 64'(oReqReady), 64'(1));
        repeat (2) tick();

        mosiLog.delete(); selCount = 0;
        issue(1'b1, 15'h0034, 16'hBEEF);
        waitIdle(100);
        check("wr_mosi_bytes", 64'({mosiLog[0], mosiLog[1], mosiLog[2], mosiLog[3]}), 64'h EFBE3480);
        check("wr_rising_edges", 64'(mosiLog.size()), 64'(7));
        check("wr_select_cycles", 64'(selCount), 64'(24));
        check("wr_rsp_latency", 64'(rspCycle - accCycle), 64'(29));

        tick();
        mosiLog.delete(); selCount = 0; r0 = rspCount;
        issue(1'b0, 15'h0100, 16'h0000);
        waitIdle(200);
        check("rd_frame1_bytes", 64'({mosiLog[0], mosiLog[1], mosiLog[2], mosiLog[3]}), 64'h0000_0001);
        check("rd_frame2_bytes", 64'({mosiLog[7], mosiLog[8], mosiLog[9], mosiLog[10]}), 64'h0000_0001);
        check("rd_select_cycles", 64'(selCount), 64'(48));
        check("rd_rsp_data", 64'(oRspData), 64'h1234_5678);
        check("rd_rsp_latency", 64'(rspCycle - accCycle), 64'(57));
        check("rd_rsp_pulses", 64'(rspCount - r0), 64'(1));

        iReqValid = 1'b1; iReqWrite = 1'b1; iReqAddr = 15'h00A5; iReqData = 16'h1357;
        waitAccept(50);
        iReqWrite = 1'b0; iReqAddr = 15'h0100; iReqData = 16'h0000;
        waitAccept(200);
        check("bp_second_accept", 64'(accCycle), 64'(rspCycle + 1));
        iReqValid = 1'b0;
        waitIdle(200);
        check("bp_rd_data", 64'(oRspData), 64'h1234_5678);

        tick();
        issue(1'b0, 15'h0222, 16'h0000);
        r0 = rspCount;
        while (cyc < accCycle + 10) tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("mid_reset_bus", 64'({oBusSelect, oBusClock, oBusMOSI}), 64'(0));
        check("mid_reset_busy", 64'(oBusy), 64'(0));
        repeat (70) tick();
        check("mid_reset_no_rsp", 64'(rspCount - r0), 64'(0));
        issue(1'b1, 15'h7FFF, 16'h0001);
        waitIdle(100);
        check("post_reset_wr_latency", 64'(rspCycle - accCycle), 64'(29));

        tick();
        issue(1'b1, 15'h0010, 16'hCAFE);
        intHighCount = 0; firstIntHigh = -1;
        repeat (3) tick();
        iBusInterrupt = 1'b1;
        raise = cyc;
        repeat (3) tick();
        iBusInterrupt = 1'b0;
        waitIdle(100);
        repeat (3) tick();
        check("irq_high_cycles", 64'(intHighCount), 64'(3));
        check("irq_latency", 64'(firstIntHigh - raise), 64'(2));
        check("irq_wr_latency", 64'(rspCycle - accCycle), 64'(29));

        randIrq = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 15'($urandom);
            issue(wr, a, wr ? 16'($urandom) : 16'h0000);
            waitIdle(200);
            if (!wr) check("rand_rd_data", 64'(oRspData), 64'(readValue(a)));
            check("rand_latency", 64'(rspCycle - accCycle), 64'(wr ? 29 : 57));
            repeat ($urandom_range(0, 3)) tick();
        end
        randIrq = 1'b0;
        iBusInterrupt = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
